uart_tx_fifo: RTL and testbench

//  Byte FIFO that sits directly upstream of the uart transmitter: host logic writes bursts at clk rate,

---
 rtl/uart_tx_fifo_pkg.sv | 14 +
 rtl/uart_fifo_mem.sv | 27 ++
 rtl/uart_tx_fifo.sv | 158 +++++++++++++++
 tb/tb_uart_tx_fifo.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the UART transmit FIFO: drain FSM encoding and default sizing.
package uart_tx_fifo_pkg;

  localparam int DEFAULT_DEPTH = 16;
  localparam int DEFAULT_AW    = 4;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } drain_state_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// DEPTH x 8 byte storage for the UART transmit FIFO: synchronous write, asynchronous read.
module uart_fifo_mem
  import uart_tx_fifo_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = DEFAULT_AW
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem_r [DEPTH];

  // Byte store; contents need no reset since level gates every read.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the UART transmitter; drains one byte per frame via tx_wr/tx_busy handshake.
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int DEPTH     = DEFAULT_DEPTH,
  parameter int AW        = DEFAULT_AW,
  parameter int AFULL_LVL = DEPTH - 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  wr_data,
  input  logic        wr_en,
  output logic        full,
  output logic        almost_full,
  output logic [AW:0] level,
  output logic        overflow,
  input  logic        ovf_clr,
  output logic        idle,
  output logic [7:0]  uart_tx_data,
  output logic        uart_tx_wr,
  input  logic        uart_tx_busy
);

  localparam logic [AW:0]   LVL_ZERO  = {(AW+1){1'b0}};
  localparam logic [AW:0]   LVL_ONE   = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0]   LVL_DEPTH = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LVL_AFULL = (AW+1)'(AFULL_LVL);
  localparam logic [AW-1:0] PTR_ONE   = {{(AW-1){1'b0}}, 1'b1};

  logic [AW-1:0] wp_r;
  logic [AW-1:0] rp_r;
  logic [AW:0]   level_r;
  logic [AW:0]   level_nxt_s;
  logic          full_r;
  logic          afull_r;
  logic          overflow_r;
  logic          idle_r;
  logic          idle_nxt_s;
  logic          push_s;
  logic          drop_s;
  logic          pop_s;
  logic [7:0]    rd_data_s;
  logic [7:0]    tx_data_r;
  logic          tx_wr_r;
  drain_state_t  state_r;

  uart_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push_s),
    .wr_addr (wp_r),
    .wr_data (wr_data),
    .rd_addr (rp_r),
    .rd_data (rd_data_s)
  );

  // Write/pop qualification and next level; full is the registered flag, so a pop never frees a slot early.
  always_comb begin
    push_s      = wr_en & ~full_r;
    drop_s      = wr_en & full_r;
    pop_s       = (state_r == ST_IDLE) && (level_r != LVL_ZERO) && !uart_tx_busy;
    level_nxt_s = level_r;
    case ({push_s, pop_s})
      2'b10:   level_nxt_s = level_r + LVL_ONE;
      2'b01:   level_nxt_s = level_r - LVL_ONE;
      default: level_nxt_s = level_r;
    endcase
    if ((state_r == ST_IDLE) && !pop_s) begin
      idle_nxt_s = (level_nxt_s == LVL_ZERO) && !uart_tx_busy;
    end else if (state_r == ST_WAIT_DONE) begin
      idle_nxt_s = (level_nxt_s == LVL_ZERO) && !uart_tx_busy;
    end else begin
      idle_nxt_s = 1'b0;
    end
  end

  // Pointers, fill level, flags and sticky overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      wp_r       <= {AW{1'b0}};
      rp_r       <= {AW{1'b0}};
      level_r    <= LVL_ZERO;
      full_r     <= 1'b0;
      afull_r    <= 1'b0;
      overflow_r <= 1'b0;
      idle_r     <= ~uart_tx_busy;
    end else begin
      if (push_s) begin
        wp_r <= wp_r + PTR_ONE;
      end
      if (pop_s) begin
        rp_r <= rp_r + PTR_ONE;
      end
      level_r <= level_nxt_s;
      full_r  <= (level_nxt_s == LVL_DEPTH);
      afull_r <= (level_nxt_s >= LVL_AFULL);
      idle_r  <= idle_nxt_s;
      // A drop in the same cycle as a clear keeps the flag set.
      if (drop_s) begin
        overflow_r <= 1'b1;
      end else if (ovf_clr) begin
        overflow_r <= 1'b0;
      end
    end
  end

  // Drain FSM: one tx_wr per frame, re-armed only after the UART has gone busy and returned idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      tx_wr_r   <= 1'b0;
      tx_data_r <= 8'h00;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (pop_s) begin
            tx_data_r <= rd_data_s;
            tx_wr_r   <= 1'b1;
            state_r   <= ST_ISSUE;
          end else begin
            tx_wr_r   <= 1'b0;
          end
        end
        ST_ISSUE: begin
          tx_wr_r <= 1'b0;
          state_r <= ST_WAIT_BUSY;
        end
        ST_WAIT_BUSY: begin
          tx_wr_r <= 1'b0;
          if (uart_tx_busy) begin
            state_r <= ST_WAIT_DONE;
          end
        end
        ST_WAIT_DONE: begin
          tx_wr_r <= 1'b0;
          if (!uart_tx_busy) begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          tx_wr_r <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign full         = full_r;
  assign almost_full  = afull_r;
  assign level        = level_r;
  assign overflow     = overflow_r;
  assign idle         = idle_r;
  assign uart_tx_data = tx_data_r;
  assign uart_tx_wr   = tx_wr_r;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomized scoreboard bench for uart_tx_fifo with a behavioural UART busy model.
module tb_uart_tx_fifo;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int AFULL = DEPTH - 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  wr_data = 8'h00;
  logic        wr_en = 1'b0;
  logic        ovf_clr = 1'b0;
  logic        uart_tx_busy = 1'b0;
  logic        full, almost_full, overflow, idle, uart_tx_wr;
  logic [AW:0] level;
  logic [7:0]  uart_tx_data;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: bytes held in the FIFO, bytes owed to the line, and the frame engine phase.
  logic [7:0] mq[$];
  logic [7:0] sb[$];
  int  phase = 0;       // 0 ready, 1 just issued, 2 awaiting busy, 3 awaiting end of frame
  bit  m_ovf = 0;
  bit  m_idle = 1;
  bit  exp_wr = 0;

  // UART model state
  bit  u_busy = 0;
  bit  force_busy = 0;
  int  u_cnt = 0;

  uart_tx_fifo #(.DEPTH(DEPTH), .AW(AW), .AFULL_LVL(AFULL)) dut (
    .clk(clk), .reset(reset), .wr_data(wr_data), .wr_en(wr_en),
    .full(full), .almost_full(almost_full), .level(level), .overflow(overflow),
    .ovf_clr(ovf_clr), .idle(idle), .uart_tx_data(uart_tx_data),
    .uart_tx_wr(uart_tx_wr), .uart_tx_busy(uart_tx_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every tx_wr pulse must carry the oldest byte still owed.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (uart_tx_wr === 1'b1) begin
        if (sb.size() == 0) begin
          chk("tx_wr_unexpected", 32'd1, 32'd0);
        end else begin
          chk("tx_data", {24'd0, uart_tx_data}, {24'd0, sb.pop_front()});
        end
      end
    end
  end

  task automatic model_step();
    bit do_pop;
    bit was_full;
    if (reset) begin
      mq.delete();
      sb.delete();
      phase  = 0;
      m_ovf  = 0;
      exp_wr = 0;
      m_idle = !uart_tx_busy;
    end else begin
      do_pop   = (phase == 0) && (mq.size() != 0) && !uart_tx_busy;
      was_full = (mq.size() == DEPTH);
      case (phase)
        1: phase = 2;
        2: if (uart_tx_busy) phase = 3;
        3: if (!uart_tx_busy) phase = 0;
        default: ;
      endcase
      if (do_pop) begin
        void'(mq.pop_front());
        phase = 1;
      end
      exp_wr = do_pop;
      if (wr_en && was_full) m_ovf = 1;
      else if (ovf_clr) m_ovf = 0;
      if (wr_en && !was_full) begin
        mq.push_back(wr_data);
        sb.push_back(wr_data);
      end
      m_idle = (mq.size() == 0) && (phase == 0) && !uart_tx_busy;
    end
  endtask

  // One cycle: check outputs, advance the UART model, apply inputs, predict next edge.
  task automatic tick(input bit we, input logic [7:0] wd, input bit clr, input bit rst);
    @(negedge clk);
    chk("level", {27'd0, level}, mq.size());
    chk("full", {31'd0, full}, {31'd0, mq.size() == DEPTH});
    chk("almost_full", {31'd0, almost_full}, {31'd0, mq.size() >= AFULL});
    chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
    chk("idle", {31'd0, idle}, {31'd0, m_idle});
    chk("tx_wr", {31'd0, uart_tx_wr}, {31'd0, exp_wr});
    if (uart_tx_wr === 1'b1) begin
      u_busy = 1;
      u_cnt  = $urandom_range(8, 30);
    end else if (u_busy) begin
      u_cnt--;
      if (u_cnt == 0) u_busy = 0;
    end
    uart_tx_busy = u_busy | force_busy;
    reset   = rst;
    wr_en   = we;
    wr_data = wd;
    ovf_clr = clr;
    model_step();
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) tick(0, 8'h00, 0, 0);
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while (!(m_idle && mq.size() == 0 && sb.size() == 0 && !u_busy) && k < 3000) begin
      tick(0, 8'h00, 0, 0);
      k++;
    end
    tick(0, 8'h00, 0, 0);
    chk({name, "_drain_bound"}, {31'd0, k < 3000}, 32'd1);
  endtask

  initial begin
    int sent;
    // Reset and reset-state checks
    tick(0, 8'h00, 0, 1);
    tick(0, 8'h00, 0, 1);
    tick(0, 8'h00, 0, 0);
    chk("reset_tx_data", {24'd0, uart_tx_data}, 32'h0);
    chk("reset_level", {27'd0, level}, 32'd0);

    // Single byte: tx_wr high after the second edge
    tick(1, 8'hA5, 0, 0);
    tick(0, 8'h00, 0, 0);
    chk("lat_no_wr_yet", {31'd0, uart_tx_wr}, 32'd0);
    tick(0, 8'h00, 0, 0);
    chk("lat_wr_high", {31'd0, uart_tx_wr}, 32'd1);
    chk("lat_data", {24'd0, uart_tx_data}, 32'hA5);
    wait_idle("single");

    // Burst of 16 with the UART held busy, then a write while full, then clear
    force_busy = 1;
    for (int i = 0; i < 16; i++) tick(1, 8'(i), 0, 0);
    tick(1, 8'hEE, 0, 0);
    tick(0, 8'h00, 0, 0);
    chk("burst_full", {31'd0, full}, 32'd1);
    chk("burst_level", {27'd0, level}, 32'd16);
    chk("burst_ovf", {31'd0, overflow}, 32'd1);
    tick(1, 8'hEE, 1, 0);
    tick(0, 8'h00, 1, 0);
    tick(0, 8'h00, 0, 0);
    chk("ovf_cleared", {31'd0, overflow}, 32'd0);
    force_busy = 0;
    wait_idle("burst");

    // 40 bytes written as fast as space allows, crossing the pointer wrap
    sent = 0;
    while (sent < 40) begin
      if (mq.size() < DEPTH) begin
        tick(1, 8'($urandom), 0, 0);
        sent++;
      end else begin
        tick(0, 8'h00, 0, 0);
      end
    end
    wait_idle("wrap");

    // Random traffic including drops, clears and busy stalls
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) force_busy = ~force_busy;
      tick($urandom_range(0, 3) == 0, 8'($urandom), $urandom_range(0, 15) == 0, 0);
    end
    force_busy = 0;
    wait_idle("random");

    // Reset mid-frame with bytes queued: nothing further is sent
    for (int i = 0; i < 6; i++) tick(1, 8'(8'h40 + i), 0, 0);
    idle_cycles(5);
    tick(0, 8'h00, 0, 1);
    tick(0, 8'h00, 0, 0);
    chk("rst_mid_level", {27'd0, level}, 32'd0);
    chk("rst_mid_wr", {31'd0, uart_tx_wr}, 32'd0);
    idle_cycles(60);
    wait_idle("rst_mid");

    // UART busy held 100 cycles with three bytes queued, then released
    force_busy = 1;
    idle_cycles(2);
    for (int i = 0; i < 3; i++) tick(1, 8'(8'hC0 + i), 0, 0);
    idle_cycles(100);
    chk("stall_level", {27'd0, level}, 32'd3);
    force_busy = 0;
    wait_idle("stall");
    chk("sb_empty", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
